// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: default widths, FSM states,
// and the fill values reported for a zero divisor.
package restoring_divider_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DW_DEF-1:0] DZ_QUOTIENT  = '1;
  localparam logic [VW_DEF-1:0] DZ_REMAINDER = '1;

endpackage

// File: rtl/restoring_divider_div_trial_sub.sv
// Trial subtractor a - b via ripple full-adder cells (b inverted, carry-in 1).
// Purely combinational; no_borrow is the final carry-out.
module div_trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic b_n;
    assign b_n        = ~b[i];
    assign diff[i]    = a[i] ^ b_n ^ carry[i];
    assign carry[i+1] = (a[i] & b_n) | (a[i] & carry[i]) | (b_n & carry[i]);
  end

  assign no_borrow = carry[W];

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, under a
// start/busy/done handshake.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW:0]   rem_q, rem_d;
  logic [VW-1:0] dsr_q, dsr_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          div_by_zero_q, div_by_zero_d;

  logic [VW:0]   shifted;
  logic [VW:0]   trial;
  logic          no_borrow;

  // Dividend MSB shifts into the partial remainder; quotient bits fill dvd_q from the LSB.
  assign shifted = (rem_q << 1) | (VW+1)'(dvd_q[DW-1]);

  div_trial_sub #(.W(VW+1)) u_trial (
    .a         (shifted),
    .b         ({1'b0, dsr_q}),
    .diff      (trial),
    .no_borrow (no_borrow)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    rem_d         = rem_q;
    dsr_d         = dsr_q;
    dz_d          = dz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = CW'(DW-1);
            dz_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        rem_d = no_borrow ? trial : shifted;
        dvd_d = {dvd_q[DW-2:0], no_borrow};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (dz_q) begin
          quotient_d    = DZ_QUOTIENT;
          remainder_d   = DZ_REMAINDER;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = dvd_q;
          remainder_d   = rem_q[VW-1:0];
          div_by_zero_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      rem_q         <= '0;
      dsr_q         <= '0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      rem_q         <= rem_d;
      dsr_q         <= dsr_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider: latency, results, zero divisor,
// ignored restarts, back-to-back throughput and mid-run reset.
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-cycle start pulse; returns at the falling edge right after the accepting edge.
  task automatic kick(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 4'h6;
  endtask

  // Number of falling edges until done is seen, or -1 when the budget expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0)
      $display("FAIL reset_outputs: busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int n;
    kick(8'd200, 4'd7);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_rise: busy=%b want 1", busy);
    else pass_cnt++;
    wait_done(n);
    total_cnt++;
    if (n !== 9) $display("FAIL basic_latency: done after %0d cycles want 9", n);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_200_7: q=%0d r=%0d dz=%b busy=%b want q=28 r=4 dz=0 busy=0",
               quotient, remainder, div_by_zero, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || quotient !== 8'd28) $display("FAIL basic_pulse_hold: done=%b q=%0d want done=0 q=28", done, quotient);
    else pass_cnt++;
  endtask

  task automatic test_inverse();
    int n;
    kick(8'd225, 4'd15);
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd15 || remainder !== 4'd0)
      $display("FAIL inverse_225_15: cycles=%0d q=%0d r=%0d want 9/15/0", n, quotient, remainder);
    else pass_cnt++;
    kick(8'd255, 4'd1);
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd255 || remainder !== 4'd0)
      $display("FAIL inverse_255_1: cycles=%0d q=%0d r=%0d want 9/255/0", n, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    int n;
    kick(8'd0, 4'd5);
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd0 || remainder !== 4'd0)
      $display("FAIL edge_0_5: cycles=%0d q=%0d r=%0d want 9/0/0", n, quotient, remainder);
    else pass_cnt++;
    kick(8'd3, 4'd9);
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd0 || remainder !== 4'd3)
      $display("FAIL edge_3_9: cycles=%0d q=%0d r=%0d want 9/0/3", n, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int n;
    kick(8'd13, 4'd0);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL dz_busy: busy=%b want 0", busy);
    else pass_cnt++;
    wait_done(n);
    total_cnt++;
    if (n !== 1 || quotient !== 8'hFF || remainder !== 4'hF || div_by_zero !== 1'b1 || busy !== 1'b0)
      $display("FAIL dz_13_0: cycles=%0d q=%h r=%h dz=%b busy=%b want 1/ff/f/1/0",
               n, quotient, remainder, div_by_zero, busy);
    else pass_cnt++;
    kick(8'd13, 4'd2);
    total_cnt++;
    if (div_by_zero !== 1'b1 || quotient !== 8'hFF)
      $display("FAIL dz_hold_on_start: dz=%b q=%h want dz=1 q=ff", div_by_zero, quotient);
    else pass_cnt++;
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd6 || remainder !== 4'd1 || div_by_zero !== 1'b0)
      $display("FAIL dz_clear_13_2: cycles=%0d q=%0d r=%0d dz=%b want 9/6/1/0",
               n, quotient, remainder, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    int broken = 0;
    kick(8'd200, 4'd7);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i <= 8 && (busy !== 1'b1 || done !== 1'b0)) broken++;
      if (i == 9) begin
        total_cnt++;
        if (done !== 1'b1 || quotient !== 8'd28 || remainder !== 4'd4)
          $display("FAIL restart_result: done=%b q=%0d r=%0d want 1/28/4", done, quotient, remainder);
        else pass_cnt++;
      end
      if (i == 3) begin
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    total_cnt++;
    if (broken !== 0) $display("FAIL restart_busy: %0d bad busy/done cycles want 0", broken);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd1;
    start    = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) begin
          d2 = k;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total_cnt++;
    if (d1 !== 10 || d2 !== 20)
      $display("FAIL b2b_spacing: done at %0d and %0d want 10 and 20", d1, d2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    int n;
    kick(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0)
      $display("FAIL midrun_async_clear: busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midrun_no_done: done seen %0d times want 0", seen);
    else pass_cnt++;
    kick(8'd100, 4'd3);
    wait_done(n);
    total_cnt++;
    if (n !== 9 || quotient !== 8'd33 || remainder !== 4'd1 || div_by_zero !== 1'b0)
      $display("FAIL midrun_100_3: cycles=%0d q=%0d r=%0d dz=%b want 9/33/1/0",
               n, quotient, remainder, div_by_zero);
    else pass_cnt++;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_inverse();
    test_edges();
    test_div_zero();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
